// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: request/response records, FSM states
// and the address-fault decode used by the responder.
package dmem_responder_pkg;

    localparam int unsigned DMEM_XLEN = 32;
    localparam int unsigned DMEM_BE_W = DMEM_XLEN / 8;
    localparam int unsigned DMEM_CNT_W = 4;

    typedef struct packed {
        logic                 we;
        logic [DMEM_XLEN-1:0] addr;
        logic [DMEM_XLEN-1:0] wdata;
        logic [DMEM_BE_W-1:0] be;
    } mem_req_t;

    typedef struct packed {
        logic [DMEM_XLEN-1:0] rdata;
        logic                 err;
    } mem_rsp_t;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // Out-of-range or non-word-aligned addresses fault; the CPU aligns sub-word ops itself.
    function automatic logic addr_fault(input logic [DMEM_XLEN-1:0] addr,
                                        input int unsigned size_bytes);
        return (addr >= size_bytes) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port word-wide synchronous RAM with per-byte write enables and a
// registered read port; contents are never cleared.
module dmem_array #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [XLEN/8-1:0]        be,
    output logic [XLEN-1:0]          rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < XLEN / 8; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one CPU load/store at a time, waits LATENCY cycles,
// performs the access once on the edge entering RESP and holds the response until taken.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned MEM_SIZE_BYTES = 4096,
    parameter int unsigned LATENCY        = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [XLEN/8-1:0] req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned AW    = $clog2(MEM_SIZE_BYTES);
    localparam int unsigned WORDS = MEM_SIZE_BYTES / (XLEN / 8);
    localparam logic [DMEM_CNT_W-1:0] CNT_INIT =
        (LATENCY == 0) ? '0 : DMEM_CNT_W'(LATENCY - 1);

    if (LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 0..15");
    end
    if (XLEN != DMEM_XLEN) begin : g_bad_xlen
        $error("dmem_responder: XLEN must match the request record width");
    end
    if ((MEM_SIZE_BYTES & (MEM_SIZE_BYTES - 1)) != 0 || MEM_SIZE_BYTES < XLEN / 8) begin : g_bad_size
        $error("dmem_responder: MEM_SIZE_BYTES must be a power of two of at least one word");
    end

    dmem_state_e           state;
    mem_req_t              req_q;
    mem_req_t              req_in;
    mem_req_t              acc;
    logic [DMEM_CNT_W-1:0] cnt;
    logic                  go;
    logic                  acc_err;
    logic                  rd_sel;
    logic                  ram_en;
    logic [XLEN-1:0]       ram_rdata;

    assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

    // With zero latency the access uses the live request during the capture cycle;
    // otherwise it uses the captured copy on the last WAIT cycle.
    always_comb begin
        acc = req_q;
        go  = 1'b0;
        if (LATENCY == 0) begin
            acc = req_in;
            go  = (state == DMEM_IDLE) && req_valid;
        end else begin
            go  = (state == DMEM_WAIT) && (cnt == '0);
        end
    end

    assign acc_err = addr_fault(acc.addr, MEM_SIZE_BYTES);
    assign ram_en  = go && !acc_err && !rst;

    dmem_array #(
        .XLEN  (XLEN),
        .DEPTH (WORDS)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (acc.we),
        .addr  (acc.addr[AW-1:2]),
        .wdata (acc.wdata),
        .be    (acc.be),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DMEM_IDLE;
            cnt       <= '0;
            req_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rd_sel    <= 1'b0;
        end else begin
            unique case (state)
                DMEM_IDLE: begin
                    if (req_valid) begin
                        req_q     <= req_in;
                        req_ready <= 1'b0;
                        if (!go) begin
                            state <= DMEM_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                DMEM_WAIT: begin
                    if (!go) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DMEM_RESP: begin
                    if (rsp_ready) begin
                        state     <= DMEM_IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rd_sel    <= 1'b0;
                    end
                end
                default: state <= DMEM_IDLE;
            endcase
            if (go) begin
                state     <= DMEM_RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= acc_err;
                rd_sel    <= !acc.we && !acc_err;
            end
        end
    end

    // The RAM read register only changes on a read, so gating it keeps stalled data stable.
    assign rsp_rdata = rd_sel ? ram_rdata : '0;

    property p_rsp_stable;
        @(posedge clk) disable iff (rst)
            (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata) && $stable(rsp_err));
    endproperty
    a_rsp_stable: assert property (p_rsp_stable);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder at LATENCY 1, 4 and 0.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 4 : 0);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst;
    logic [2:0]       req_valid;
    logic [2:0]       req_ready;
    logic [2:0]       req_we;
    logic [2:0][31:0] req_addr;
    logic [2:0][31:0] req_wdata;
    logic [2:0][3:0]  req_be;
    logic [2:0]       rsp_valid;
    logic [2:0]       rsp_ready;
    logic [2:0][31:0] rsp_rdata;
    logic [2:0]       rsp_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_cyc = 0;
    exp_t sb[$];
    logic [31:0] model [3][1024];
    logic [31:0] last_rdata;
    logic        last_err;
    logic        park_we;
    logic [31:0] park_addr;
    logic [31:0] park_wdata;
    logic [3:0]  park_be;

    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .XLEN           (32),
            .MEM_SIZE_BYTES (4096),
            .LATENCY        (lat_of(g))
        ) dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on unit u: predict, drive, wait for accept and response, compare.
    task automatic xact(input int u, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int hold, input logic park, output int acc_cyc);
        exp_t        e;
        exp_t        got_e;
        logic        ferr;
        logic        got;
        int          lat;
        logic [31:0] r0;
        logic        e0;
        ferr    = (addr >= 32'd4096) || (addr[1:0] != 2'b00);
        e.err   = ferr;
        e.rdata = (!we && !ferr) ? model[u][addr[11:2]] : 32'h0;
        if (we && !ferr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[u][addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        sb.push_back(e);

        req_we[u]    = we;
        req_addr[u]  = addr;
        req_wdata[u] = wdata;
        req_be[u]    = be;
        req_valid[u] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = req_ready[u];
            tick();
        end
        acc_cyc = cyc;
        chk1("accept", got, 1'b1);
        if (park) begin
            req_we[u]    = park_we;
            req_addr[u]  = park_addr;
            req_wdata[u] = park_wdata;
            req_be[u]    = park_be;
        end else begin
            req_valid[u] = 1'b0;
        end

        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid[u]) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        chk1("rsp_seen", got, 1'b1);
        got_e = sb.pop_front();
        r0 = rsp_rdata[u];
        e0 = rsp_err[u];
        chki("latency", lat, lat_of(u) + 1);
        chk("rdata", r0, got_e.rdata);
        chk1("err", e0, got_e.err);
        chk1("rsp_req_ready", req_ready[u], 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk1("hold_valid", rsp_valid[u], 1'b1);
            chk("hold_rdata", rsp_rdata[u], r0);
            chk1("hold_req_ready", req_ready[u], 1'b0);
        end
        rsp_ready[u] = 1'b1;
        tick();
        hs_cyc     = cyc;
        last_rdata = r0;
        last_err   = e0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int prev;
        rst       = '1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = '1;
        repeat (3) tick();
        rst = '0;
        repeat (5) tick();
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk1("reset_req_ready", req_ready[u], 1'b1);
            chk1("reset_rsp_valid", rsp_valid[u], 1'b0);
            chk("reset_rsp_rdata", rsp_rdata[u], 32'h0);
            chk1("reset_rsp_err", rsp_err[u], 1'b0);
        end
        tick();

        // LATENCY=1: full store, load, partial store, load
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, a);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, a);
        chk("full_word", last_rdata, 32'hDEADBEEF);
        xact(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, 1'b0, a);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, a);
        chk("partial_word", last_rdata, 32'hDE22BE44);

        // Back-pressure with a second request parked on the request port
        park_we    = 1'b1;
        park_addr  = 32'h14;
        park_wdata = 32'hCAFEF00D;
        park_be    = 4'hF;
        rsp_ready[0] = 1'b0;
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 6, 1'b1, a);
        chk("bp_rdata", last_rdata, 32'hDE22BE44);
        prev = hs_cyc;
        xact(0, 1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 0, 1'b0, a);
        chki("parked_accept_cycle", a, prev + 1);
        xact(0, 1'b0, 32'h14, 32'h0, 4'h0, 0, 1'b0, a);
        chk("parked_store", last_rdata, 32'hCAFEF00D);

        // Faults and the be=0 no-op
        xact(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, 1'b0, a);
        chk1("oob_err", last_err, 1'b1);
        xact(0, 1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 0, 1'b0, a);
        chk1("misaligned_err", last_err, 1'b1);
        xact(0, 1'b1, 32'h10, 32'h99999999, 4'h0, 0, 1'b0, a);
        chk1("be0_err", last_err, 1'b0);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, a);
        chk("unchanged_after_faults", last_rdata, 32'hDE22BE44);

        // LATENCY=4: reset two cycles into a store abandons the write
        xact(1, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, 0, 1'b0, a);
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'h55AA55AA;
        req_be[1]    = 4'hF;
        req_valid[1] = 1'b1;
        @(negedge clk);
        chk1("rw_ready", req_ready[1], 1'b1);
        tick();
        req_valid[1] = 1'b0;
        tick();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        @(negedge clk);
        chk1("rw_ready_after_rst", req_ready[1], 1'b1);
        chk1("rw_no_rsp", rsp_valid[1], 1'b0);
        tick();
        xact(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, a);
        chk("rw_old_value", last_rdata, 32'h0BADF00D);

        // LATENCY=0: fill 16 words, then 16 back-to-back loads
        for (int i = 0; i < 16; i++) begin
            xact(2, 1'b1, 32'(i * 4), 32'hA5000000 ^ 32'(i * 32'h01010101), 4'hF, 0, 1'b0, a);
        end
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            xact(2, 1'b0, 32'(i * 4), 32'h0, 4'h0, 0, 1'b0, a);
            chk("l0_data", last_rdata, 32'hA5000000 ^ 32'(i * 32'h01010101));
            if (i > 0) chki("l0_period", a - prev, 2);
            prev = a;
        end

        chki("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
